// File: rtl/jtag_tap_target.sv
// jtag_tap_target: JTAG-DP TAP responder used as a loopback target for the probe.
// Oversamples tck/tms/tdi on clk, runs the 1149.1 TAP controller and turns
// completed DPACC/APACC scans into single DP/AP requests.
// Optional feature: define JTAG_TAP_ABORT_EN to enable the ABORT instruction (IR 1000).
module jtag_tap_target #(
    parameter logic [31:0] IDCODE = 32'h4BA00477
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tck,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    output logic        tdo_en,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_apndp,
    output logic [1:0]  req_addr,
    output logic        req_rnw,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic        resp_fault,
    input  logic [31:0] resp_rdata,
    output logic        abort
);

    localparam int unsigned IR_W = 4;
    localparam int unsigned DR_W = 35;
    localparam int unsigned ID_W = 32;

    localparam logic [IR_W-1:0] IR_IDCODE  = 4'b1110;
    localparam logic [IR_W-1:0] IR_DPACC   = 4'b1010;
    localparam logic [IR_W-1:0] IR_APACC   = 4'b1011;
    localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;
`ifdef JTAG_TAP_ABORT_EN
    localparam logic [IR_W-1:0] IR_ABORT   = 4'b1000;
`endif

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI,
        ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
        ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS, DR_IDCODE, DR_ACC, DR_ABORT
    } dr_sel_t;

    logic [1:0]      tck_sync;
    logic [1:0]      tms_sync;
    logic [1:0]      tdi_sync;
    logic            tck_prev;
    logic            tck_rise_c;
    logic            tck_fall_c;
    logic            tms_s;
    logic            tdi_s;

    tap_state_t      state;
    tap_state_t      state_nxt;

    logic            st_tlr_c;
    logic            st_cap_ir_c;
    logic            st_shift_ir_c;
    logic            st_upd_ir_c;
    logic            st_cap_dr_c;
    logic            st_shift_dr_c;
    logic            st_upd_dr_c;

    logic            cap_ir_c;
    logic            shift_ir_c;
    logic            upd_ir_c;
    logic            cap_dr_c;
    logic            shift_dr_c;
    logic            upd_dr_c;

    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_shift;
    dr_sel_t         dr_sel;
    logic [DR_W-1:0] dr_shift;

    logic            outstanding;
    logic [31:0]     last_rdata;
    logic            last_fault;
    logic [2:0]      ack_c;
    logic            issue_c;
    logic            abort_c;
    logic            unused_c;

    // Two-stage synchronisers with a shared depth so tck/tms/tdi stay aligned
    always_ff @(posedge clk) begin
        if (!rst) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[0], tck};
            tms_sync <= {tms_sync[0], tms};
            tdi_sync <= {tdi_sync[0], tdi};
            tck_prev <= tck_sync[1];
        end
    end

    assign tck_rise_c = tck_sync[1] & ~tck_prev;
    assign tck_fall_c = ~tck_sync[1] & tck_prev;
    assign tms_s      = tms_sync[1];
    assign tdi_s      = tdi_sync[1];

    // TAP state register, advanced on each synced rising tck
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_TLR;
        end else if (tck_rise_c) begin
            state <= state_nxt;
        end
    end

    // TAP next-state transitions on synced tms
    always_comb begin
        state_nxt = state;
        case (state)
            ST_TLR:      state_nxt = tms_s ? ST_TLR      : ST_RTI;
            ST_RTI:      state_nxt = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_nxt = tms_s ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_nxt = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_nxt = tms_s ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_nxt = tms_s ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_nxt = tms_s ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_nxt = tms_s ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_nxt = tms_s ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_nxt = tms_s ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_nxt = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_nxt = tms_s ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_nxt = tms_s ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_nxt = tms_s ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_nxt = tms_s ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_nxt = tms_s ? ST_SEL_DR   : ST_RTI;
            default:     state_nxt = ST_TLR;
        endcase
    end

    // State decode flags consumed by the IR/DR datapath
    always_comb begin
        st_tlr_c      = 1'b0;
        st_cap_ir_c   = 1'b0;
        st_shift_ir_c = 1'b0;
        st_upd_ir_c   = 1'b0;
        st_cap_dr_c   = 1'b0;
        st_shift_dr_c = 1'b0;
        st_upd_dr_c   = 1'b0;
        case (state)
            ST_TLR:      st_tlr_c      = 1'b1;
            ST_CAP_IR:   st_cap_ir_c   = 1'b1;
            ST_SHIFT_IR: st_shift_ir_c = 1'b1;
            ST_UPD_IR:   st_upd_ir_c   = 1'b1;
            ST_CAP_DR:   st_cap_dr_c   = 1'b1;
            ST_SHIFT_DR: st_shift_dr_c = 1'b1;
            ST_UPD_DR:   st_upd_dr_c   = 1'b1;
            default:     ;
        endcase
    end

    // TAP actions happen on the rising event while in the owning state
    assign cap_ir_c   = tck_rise_c & st_cap_ir_c;
    assign shift_ir_c = tck_rise_c & st_shift_ir_c;
    assign upd_ir_c   = tck_rise_c & st_upd_ir_c;
    assign cap_dr_c   = tck_rise_c & st_cap_dr_c;
    assign shift_dr_c = tck_rise_c & st_shift_dr_c;
    assign upd_dr_c   = tck_rise_c & st_upd_dr_c;

    // Instruction decode into the selected data register
    always_comb begin
        dr_sel = DR_BYPASS;
        case (ir)
            IR_IDCODE: dr_sel = DR_IDCODE;
            IR_DPACC:  dr_sel = DR_ACC;
            IR_APACC:  dr_sel = DR_ACC;
`ifdef JTAG_TAP_ABORT_EN
            IR_ABORT:  dr_sel = DR_ABORT;
`endif
            default:   dr_sel = DR_BYPASS;
        endcase
    end

    // Instruction register: capture/shift/update, held at IDCODE in Test-Logic-Reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ir       <= IR_IDCODE;
            ir_shift <= '0;
        end else begin
            if (st_tlr_c) begin
                ir <= IR_IDCODE;
            end else if (upd_ir_c) begin
                ir <= ir_shift;
            end
            if (cap_ir_c) begin
                ir_shift <= IR_CAPTURE;
            end else if (shift_ir_c) begin
                ir_shift <= {tdi_s, ir_shift[IR_W-1:1]};
            end
        end
    end

    assign ack_c = outstanding ? 3'b001 : 3'b010;

    // Data shift register; tdi enters at the MSB of the selected register length
    always_ff @(posedge clk) begin
        if (!rst) begin
            dr_shift <= '0;
        end else if (cap_dr_c) begin
            case (dr_sel)
                DR_IDCODE: dr_shift <= DR_W'(IDCODE);
                DR_ACC,
                DR_ABORT:  dr_shift <= {last_rdata, ack_c};
                default:   dr_shift <= '0;
            endcase
        end else if (shift_dr_c) begin
            case (dr_sel)
                DR_IDCODE: dr_shift <= DR_W'({tdi_s, dr_shift[ID_W-1:1]});
                DR_ACC,
                DR_ABORT:  dr_shift <= {tdi_s, dr_shift[DR_W-1:1]};
                default:   dr_shift <= DR_W'(tdi_s);
            endcase
        end
    end

    // tdo/tdo_en change on the falling event, as a real TAP drives TDO
    always_ff @(posedge clk) begin
        if (!rst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (tck_fall_c) begin
            tdo_en <= st_shift_ir_c | st_shift_dr_c;
            if (st_shift_ir_c) begin
                tdo <= ir_shift[0];
            end else if (st_shift_dr_c) begin
                tdo <= dr_shift[0];
            end else begin
                tdo <= 1'b0;
            end
        end
    end

    // A completion landing with the update frees the slot for the new request
    assign issue_c = upd_dr_c && (dr_sel == DR_ACC) && !(outstanding && !resp_valid);

`ifdef JTAG_TAP_ABORT_EN
    assign abort_c = upd_dr_c && (dr_sel == DR_ABORT) && dr_shift[3];
`else
    assign abort_c = 1'b0;
`endif

    // Request issue, handshake and completion tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding <= 1'b0;
            last_rdata  <= '0;
            last_fault  <= 1'b0;
            req_valid   <= 1'b0;
            req_apndp   <= 1'b0;
            req_addr    <= '0;
            req_rnw     <= 1'b0;
            req_wdata   <= '0;
            abort       <= 1'b0;
        end else begin
            abort <= abort_c;
            if (resp_valid) begin
                last_rdata <= resp_rdata;
                last_fault <= resp_fault;
            end
            if (issue_c) begin
                outstanding <= 1'b1;
            end else if (resp_valid || abort_c) begin
                outstanding <= 1'b0;
            end
            if (issue_c) begin
                req_valid <= 1'b1;
                req_apndp <= (ir == IR_APACC);
                req_addr  <= dr_shift[2:1];
                req_rnw   <= dr_shift[0];
                req_wdata <= dr_shift[DR_W-1:3];
            end else if (req_ready) begin
                req_valid <= 1'b0;
            end
        end
    end

    // Fault status is kept for debug visibility only
    assign unused_c = last_fault;

endmodule

// File: tb/tb_jtag_tap_target.sv
// tb_jtag_tap_target: directed + randomized scans against a scan-level model of the target.
module tb_jtag_tap_target;

    localparam logic [31:0] IDCODE_VAL = 32'h4BA00477;
    localparam logic [3:0]  IR_IDCODE  = 4'b1110;
    localparam logic [3:0]  IR_DPACC   = 4'b1010;
    localparam logic [3:0]  IR_APACC   = 4'b1011;
    localparam logic [3:0]  IR_ABORT   = 4'b1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tck;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        tdo_en;
    logic        req_valid;
    logic        req_ready;
    logic        req_apndp;
    logic [1:0]  req_addr;
    logic        req_rnw;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_fault;
    logic [31:0] resp_rdata;
    logic        abort;

    int vectors      = 0;
    int miscompares  = 0;
    int req_rises    = 0;
    int abort_cycles = 0;
    logic req_prev   = 1'b0;

    // Scan-level model: active IR, outstanding flag, last read data, pending request fields
    logic [3:0]  ir_m;
    logic        out_m;
    logic [31:0] rdata_m;
    logic [35:0] req_m;

    jtag_tap_target dut (
        .clk        (clk),
        .rst        (rst),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_apndp  (req_apndp),
        .req_addr   (req_addr),
        .req_rnw    (req_rnw),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_fault (resp_fault),
        .resp_rdata (resp_rdata),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    // Count request launches and abort-high cycles
    always @(posedge clk) req_prev <= req_valid;
    always @(posedge clk) if (req_valid === 1'b1 && req_prev !== 1'b1) req_rises++;
    always @(posedge clk) if (abort === 1'b1) abort_cycles++;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCK period; tdo/tdo_en sampled just before the rising edge
    task automatic tick(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic en_v);
        tms = tms_v;
        tdi = tdi_v;
        repeat (6) @(negedge clk);
        tdo_v = tdo;
        en_v  = tdo_en;
        tck   = 1'b1;
        repeat (6) @(negedge clk);
        tck   = 1'b0;
    endtask

    // Run-Test/Idle -> IR scan -> Run-Test/Idle
    task automatic scan_ir(input logic [3:0] v);
        logic t, e, en_in, en_out;
        logic [3:0] cap;
        tick(1'b1, 1'b0, t, e);
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        en_out = e;
        en_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(i == 3, v[i], t, e);
            cap[i] = t;
            en_in  = en_in & e;
        end
        tick(1'b1, 1'b0, t, e);
        en_out = en_out | e;
        tick(1'b0, 1'b0, t, e);
        en_out = en_out | e;
        check("ir_capture", 64'(cap), 64'(4'b0001));
        check("ir_tdo_en", 64'({en_in, en_out}), 64'(2'b10));
        ir_m = v;
    endtask

    // Run-Test/Idle -> n-bit DR scan -> Run-Test/Idle
    task automatic scan_dr(input logic [34:0] din, input int n, output logic [34:0] dout);
        logic t, e, en_in, en_out;
        dout = '0;
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        en_out = e;
        en_in  = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i], t, e);
            dout[i] = t;
            en_in   = en_in & e;
        end
        tick(1'b1, 1'b0, t, e);
        en_out = en_out | e;
        tick(1'b0, 1'b0, t, e);
        en_out = en_out | e;
        check("dr_tdo_en", 64'({en_in, en_out}), 64'(2'b10));
    endtask

    task automatic wait_req(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_valid_seen", 64'(ok), 64'd1);
    endtask

    task automatic accept();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("req_held", 64'({req_valid, req_apndp, req_addr, req_rnw, req_wdata}), 64'({1'b1, req_m}));
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("req_drop", 64'(req_valid), 64'd0);
    endtask

    task automatic respond(input logic [31:0] rd, input logic flt);
        resp_valid = 1'b1;
        resp_rdata = rd;
        resp_fault = flt;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        rdata_m    = rd;
        out_m      = 1'b0;
    endtask

    // DPACC/APACC scan: check captured {rdata, ack} and whether a request results
    task automatic acc_scan(input logic [34:0] din);
        logic [34:0] dout;
        logic ok;
        int r0;
        r0 = req_rises;
        scan_dr(din, 35, dout);
        check("acc_capture", 64'(dout), 64'({rdata_m, out_m ? 3'b001 : 3'b010}));
        if (!out_m) begin
            req_m = {ir_m == IR_APACC, din[2:1], din[0], din[34:3]};
            wait_req(ok);
            check("req_fields", 64'({req_apndp, req_addr, req_rnw, req_wdata}), 64'(req_m));
            check("req_issued", 64'(req_rises - r0), 64'd1);
            out_m = 1'b1;
            accept();
        end else begin
            repeat (4) @(negedge clk);
            check("wait_no_req", 64'({req_valid, 32'(req_rises - r0)}), 64'd0);
            check("wait_fields_held", 64'({req_apndp, req_addr, req_rnw, req_wdata}), 64'(req_m));
        end
    endtask

    task automatic bypass_scan(input logic [3:0] v, input logic [7:0] d);
        logic [34:0] dout;
        logic [34:0] din;
        scan_ir(v);
        din = {26'd0, 1'($urandom_range(0, 1)), d};
        scan_dr(din, 9, dout);
        check("bypass", 64'(dout), 64'({d, 1'b0}));
    endtask

    task automatic idcode_scan();
        logic [34:0] dout;
        logic [63:0] r;
        r = {$urandom, $urandom};
        scan_dr(r[34:0], 32, dout);
        check("idcode", 64'(dout), 64'(IDCODE_VAL));
    endtask

    function automatic logic [34:0] rand_din();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[34:0];
    endfunction

    initial begin
        logic t, e;
        logic [34:0] dout;
        logic [34:0] din;
        logic [3:0]  v;
        int r0, a0, kind;

        rst = 1'b0; tck = 1'b0; tms = 1'b0; tdi = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_fault = 1'b0; resp_rdata = '0;
        ir_m = IR_IDCODE; out_m = 1'b0; rdata_m = '0; req_m = '0;

        // Reset and IDCODE selected by default
        repeat (4) @(negedge clk);
        check("reset_outputs", 64'({tdo, tdo_en, req_valid, req_apndp, req_addr, req_rnw, req_wdata, abort}), 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        idcode_scan();

        // BYPASS through two different unassigned opcodes
        bypass_scan(4'b1111, 8'hA5);
        bypass_scan(4'b0011, 8'hA5);

        // DPACC write, then a DPACC read seeing OK once completed
        scan_ir(IR_DPACC);
        acc_scan({32'h12345678, 2'b01, 1'b0});
        respond(32'h0, 1'b0);
        acc_scan({32'h0, 2'b11, 1'b1});
        respond(32'h5A5A0001, 1'b1);

        // WAIT while an APACC read is in flight
        scan_ir(IR_APACC);
        acc_scan({32'h0, 2'b10, 1'b1});
        acc_scan(rand_din());
        respond(32'hCAFEF00D, 1'b0);
        acc_scan({32'h0, 2'b00, 1'b1});
        respond($urandom, 1'b0);

        // Reset in the middle of a DPACC shift with a request outstanding
        scan_ir(IR_DPACC);
        acc_scan(rand_din());
        r0 = req_rises;
        tick(1'b1, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        tick(1'b0, 1'b0, t, e);
        for (int i = 0; i < 17; i++) tick(1'b0, 1'($urandom_range(0, 1)), t, e);
        rst = 1'b0; req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'hDEADBEEF;
        repeat (4) @(negedge clk);
        check("midscan_reset_outputs", 64'({tdo, tdo_en, req_valid, req_apndp, req_addr, req_rnw, req_wdata, abort}), 64'd0);
        rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0;
        ir_m = IR_IDCODE; out_m = 1'b0; rdata_m = '0; req_m = '0;
        tick(1'b0, 1'b0, t, e);
        idcode_scan();
        repeat (10) @(negedge clk);
        check("midscan_no_req", 64'({req_valid, 32'(req_rises - r0)}), 64'd0);
        scan_ir(IR_DPACC);
        acc_scan(rand_din());
        respond($urandom, 1'b0);

`ifdef JTAG_TAP_ABORT_EN
        // ABORT with data[0]=0 does nothing; data[0]=1 pulses abort and frees the slot
        scan_ir(IR_DPACC);
        acc_scan(rand_din());
        a0 = abort_cycles;
        r0 = req_rises;
        scan_ir(IR_ABORT);
        din = rand_din();
        din[3] = 1'b0;
        scan_dr(din, 35, dout);
        repeat (4) @(negedge clk);
        check("abort_data0_clear", 64'(abort_cycles - a0), 64'd0);
        din[3] = 1'b1;
        scan_dr(din, 35, dout);
        repeat (4) @(negedge clk);
        check("abort_pulse", 64'(abort_cycles - a0), 64'd1);
        check("abort_no_req", 64'(req_rises - r0), 64'd0);
        out_m = 1'b0;
        respond(32'h0BADC0DE, 1'b1);
        scan_ir(IR_DPACC);
        acc_scan(rand_din());
        respond($urandom, 1'b0);
`else
        // Without the ABORT option, 1000 is just another BYPASS opcode
        a0 = abort_cycles;
        bypass_scan(IR_ABORT, 8'h3C);
        check("abort_tied_low", 64'(abort_cycles - a0), 64'd0);
`endif

        // Randomized mix of scans, with completions sometimes held off
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                do v = 4'($urandom_range(0, 15));
                while (v == IR_IDCODE || v == IR_DPACC || v == IR_APACC || v == IR_ABORT);
                bypass_scan(v, 8'($urandom));
            end else if (kind == 1) begin
                scan_ir(IR_IDCODE);
                idcode_scan();
            end else begin
                scan_ir(kind == 2 ? IR_DPACC : IR_APACC);
                acc_scan(rand_din());
                if ($urandom_range(0, 1) == 1) respond($urandom, 1'($urandom_range(0, 1)));
            end
        end
        if (out_m) respond($urandom, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
